// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_pkg
// Purpose  : Shared opcodes, control-level constants, sequencer state
//            encoding and opcode-class helpers for muldiv_seq and div_core.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_seq_pkg;

    localparam logic [7:0] EXE_MADD_OP  = 8'b10100110;
    localparam logic [7:0] EXE_MADDU_OP = 8'b10101000;
    localparam logic [7:0] EXE_MSUB_OP  = 8'b10101010;
    localparam logic [7:0] EXE_MSUBU_OP = 8'b10101011;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MAC     = 2'b01,
        DIV_RUN = 2'b10,
        DIV_END = 2'b11
    } state_t;

    function automatic logic is_mac_op(input logic [7:0] op);
        return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
               (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
    endfunction

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == EXE_MADD_OP) || (op == EXE_MSUB_OP) || (op == EXE_DIV_OP);
    endfunction

    function automatic logic is_msub_op(input logic [7:0] op);
        return (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
    endfunction

endpackage : muldiv_seq_pkg
`default_nettype wire

// File: rtl/div_core.sv
`default_nettype none
// ============================================================================
// Module   : div_core
// Purpose  : Iterative restoring divider on unsigned 32-bit magnitudes,
//            one quotient bit per cycle, DIV_ITER cycles after start.
// Ports    : clk, rst        - clock / synchronous active-high reset
//            start           - load operands and begin (1-cycle pulse)
//            annul           - abandon the division in flight
//            dividend/divisor- unsigned operands sampled on start
//            done            - result valid, held until next start/annul
//            quotient/remainder - unsigned result
// Revision : 1.0 - initial release
// ============================================================================
module div_core
    import muldiv_seq_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        annul,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_quo;
    logic [31:0]   r_rem;
    logic [31:0]   r_dsr;

    // Partial remainder shifted left with the next dividend bit brought in.
    // Bit 32 of the difference is the borrow: set means the trial failed.
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dsr};

    always_ff @(posedge clk) begin
        if (rst == RstEnable || annul) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= ZeroWord;
            r_rem  <= ZeroWord;
            r_dsr  <= ZeroWord;
        end else if (start) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= dividend;
            r_rem  <= ZeroWord;
            r_dsr  <= divisor;
        end else if (r_busy) begin
            if (w_diff[32]) begin
                r_rem <= w_shift[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end else begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end
            if (r_cnt == CW'(DIV_ITER - 1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule : div_core
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Sequences multi-cycle HI/LO operations (MADD/MADDU/MSUB/MSUBU,
//            DIV/DIVU) beside the execute stage: stalls the pipeline until
//            the result is ready, then presents a one-cycle HI/LO write.
// Ports    : clk, rst          - clock / synchronous active-high reset
//            aluop_i           - opcode of the instruction in execute
//            reg1_i, reg2_i    - operands (multiplicand/dividend, multiplier/divisor)
//            hi_i, lo_i        - forwarded current HI/LO (accumulate source)
//            annul_i           - flush, aborts anything in flight
//            stallreq_o        - pipeline stall request
//            whilo_o           - HI/LO write enable pulse
//            hi_o, lo_o        - HI/LO write data
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        annul_i,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

    state_t        r_state;
    logic [63:0]   r_prod;
    logic [CW-1:0] r_cnt;
    logic          r_is_div;    // class of the latched op: 1 = divide, 0 = MAC
    logic          r_div_zero;  // divisor was zero: result forced to 0/0
    logic          r_quo_neg;
    logic          r_rem_neg;

    logic        w_is_mac;
    logic        w_is_div;
    logic        w_signed;
    logic        w_abort;
    logic        w_start;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic [63:0] w_mac_sum;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dsr_mag;
    logic        w_core_done;
    logic [31:0] w_core_quo;
    logic [31:0] w_core_rem;
    logic [31:0] w_div_lo;
    logic [31:0] w_div_hi;

    assign w_is_mac = is_mac_op(aluop_i);
    assign w_is_div = is_div_op(aluop_i);
    assign w_signed = is_signed_op(aluop_i);

    // A flush, or the opcode leaving the class of the op in flight, kills it.
    assign w_abort = annul_i ||
                     ((r_state != IDLE) && (r_is_div ? !w_is_div : !w_is_mac));

    // 64x64 multiply of the extended operands; the low 64 bits are the exact
    // signed or unsigned 32x32 product.
    assign w_a64  = w_signed ? {{32{reg1_i[31]}}, reg1_i} : {32'h0, reg1_i};
    assign w_b64  = w_signed ? {{32{reg2_i[31]}}, reg2_i} : {32'h0, reg2_i};
    assign w_prod = w_a64 * w_b64;

    assign w_mac_sum = r_prod + {hi_i, lo_i};

    assign w_dvd_mag = (w_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign w_dsr_mag = (w_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

    assign w_start = (r_state == IDLE) && !annul_i && w_is_div && (reg2_i != ZeroWord);

    div_core #(
        .DIV_ITER (DIV_ITER)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .annul     (w_abort),
        .dividend  (w_dvd_mag),
        .divisor   (w_dsr_mag),
        .done      (w_core_done),
        .quotient  (w_core_quo),
        .remainder (w_core_rem)
    );

    // Quotient sign follows the operand signs; remainder takes the dividend's.
    assign w_div_lo = r_div_zero ? ZeroWord : (r_quo_neg ? (~w_core_quo + 32'd1) : w_core_quo);
    assign w_div_hi = r_div_zero ? ZeroWord : (r_rem_neg ? (~w_core_rem + 32'd1) : w_core_rem);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state    <= IDLE;
            r_prod     <= 64'h0;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_quo_neg  <= 1'b0;
            r_rem_neg  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!annul_i && w_is_mac) begin
                        r_prod   <= is_msub_op(aluop_i) ? (~w_prod + 64'd1) : w_prod;
                        r_is_div <= 1'b0;
                        r_state  <= MAC;
                    end else if (!annul_i && w_is_div) begin
                        r_is_div   <= 1'b1;
                        r_cnt      <= '0;
                        r_div_zero <= (reg2_i == ZeroWord);
                        r_quo_neg  <= w_signed && (reg1_i[31] ^ reg2_i[31]);
                        r_rem_neg  <= w_signed && reg1_i[31];
                        r_state    <= (reg2_i == ZeroWord) ? DIV_END : DIV_RUN;
                    end
                end
                MAC: begin
                    r_state <= IDLE;
                end
                DIV_RUN: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else if (r_cnt == CW'(DIV_ITER - 1)) begin
                        r_state <= DIV_END;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DIV_END: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stallreq_o = NoStop;
        whilo_o    = WriteDisable;
        hi_o       = ZeroWord;
        lo_o       = ZeroWord;
        case (r_state)
            IDLE: begin
                if (!annul_i && (w_is_mac || w_is_div)) begin
                    stallreq_o = Stop;
                end
            end
            MAC: begin
                if (!w_abort) begin
                    whilo_o = WriteEnable;
                    hi_o    = w_mac_sum[63:32];
                    lo_o    = w_mac_sum[31:0];
                end
            end
            DIV_RUN: begin
                if (!w_abort) begin
                    stallreq_o = Stop;
                end
            end
            DIV_END: begin
                if (!w_abort && (r_div_zero || w_core_done)) begin
                    whilo_o = WriteEnable;
                    hi_o    = w_div_hi;
                    lo_o    = w_div_lo;
                end
            end
            default: begin
                stallreq_o = NoStop;
            end
        endcase
    end

endmodule : muldiv_seq
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Self-checking bench for muldiv_seq: directed cases with literal
//            expectations plus randomized traffic checked every cycle
//            against a latency/arithmetic reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop_i = 8'h00;
    logic [31:0] reg1_i = 32'h0;
    logic [31:0] reg2_i = 32'h0;
    logic [31:0] hi_i = 32'h0;
    logic [31:0] lo_i = 32'h0;
    logic        annul_i = 1'b0;
    logic        stallreq_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: an op in flight needs m_k more stall cycles,
    // then produces m_res in its write cycle.
    bit          m_ready  = 1'b0;
    bit          m_active = 1'b0;
    bit          m_div    = 1'b0;
    int          m_k      = 0;
    logic [63:0] m_res    = 64'h0;

    muldiv_seq #(.DIV_ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .annul_i    (annul_i),
        .stallreq_o (stallreq_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    function automatic bit tb_is_mac(input logic [7:0] op);
        return op == 8'b10100110 || op == 8'b10101000 || op == 8'b10101010 || op == 8'b10101011;
    endfunction

    function automatic bit tb_is_div(input logic [7:0] op);
        return op == 8'b00011010 || op == 8'b00011011;
    endfunction

    // {HI,LO} the op must write, from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'h0;
        case (op)
            EXE_MADD_OP, EXE_MSUB_OP:   p = sa * sb;
            EXE_MADDU_OP, EXE_MSUBU_OP: p = {32'h0, a} * {32'h0, b};
            EXE_DIV_OP: begin
                if (b == 0) return 64'h0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            EXE_DIVU_OP: begin
                if (b == 0) return 64'h0;
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
        if (op == EXE_MSUB_OP || op == EXE_MSUBU_OP) p = -p;
        return p + {h, l};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model advance on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_ready  = 1'b1;
            m_active = 1'b0;
        end else if (m_ready) begin
            if (m_active) begin
                if (annul_i || (m_div ? !tb_is_div(aluop_i) : !tb_is_mac(aluop_i)) || m_k == 0)
                    m_active = 1'b0;
                else
                    m_k--;
            end else if (!annul_i && (tb_is_mac(aluop_i) || tb_is_div(aluop_i))) begin
                m_active = 1'b1;
                m_div    = tb_is_div(aluop_i);
                m_res    = ref_result(aluop_i, reg1_i, reg2_i, hi_i, lo_i);
                m_k      = (!m_div || reg2_i == 0) ? 0 : 32;
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        logic        e_stall, e_we, ab;
        logic [63:0] e_hl;
        if (m_ready) begin
            e_stall = 1'b0; e_we = 1'b0; e_hl = 64'h0;
            if (!m_active) begin
                e_stall = !annul_i && (tb_is_mac(aluop_i) || tb_is_div(aluop_i));
            end else begin
                ab = annul_i || (m_div ? !tb_is_div(aluop_i) : !tb_is_mac(aluop_i));
                if (m_k > 0) begin
                    e_stall = !ab;
                end else begin
                    e_we = !ab;
                    e_hl = ab ? 64'h0 : m_res;
                end
            end
            chk("model_stallreq", {63'h0, stallreq_o}, {63'h0, e_stall});
            chk("model_whilo", {63'h0, whilo_o}, {63'h0, e_we});
            chk("model_hilo", {hi_o, lo_o}, e_hl);
        end
    end

    // Called just after a rising edge; counts stall cycles then checks the write.
    task automatic do_op(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                         input int exp_stall, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        aluop_i = op; reg1_i = a; reg2_i = b; hi_i = h; lo_i = l;
        n = 0;
        @(negedge clk);
        while (stallreq_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_stalls"}, 64'(n), 64'(exp_stall));
        chk({name, "_whilo"}, {63'h0, whilo_o}, 64'h1);
        chk({name, "_hi"}, {32'h0, hi_o}, {32'h0, exp_hi});
        chk({name, "_lo"}, {32'h0, lo_o}, {32'h0, exp_lo});
        @(posedge clk); #1;
        aluop_i = 8'h00;
    endtask

    function automatic logic [7:0] pick_op(input int r);
        case (r)
            0: return EXE_MADD_OP;
            1: return EXE_MADDU_OP;
            2: return EXE_MSUB_OP;
            3: return EXE_MSUBU_OP;
            4: return EXE_DIV_OP;
            5: return EXE_DIVU_OP;
            6: return 8'h21;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        int nw;
        // Model pins against hand-computed values.
        chk("pin_madd", ref_result(EXE_MADD_OP, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h10), 64'h0000_0000_0000_000A);
        chk("pin_msubu", ref_result(EXE_MSUBU_OP, 32'hFFFF_FFFF, 32'd2, 32'h2, 32'h0), 64'h0000_0000_0000_0002);
        chk("pin_div_neg", ref_result(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("pin_div_ovf", ref_result(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0), 64'h0000_0000_8000_0000);
        chk("pin_divu", ref_result(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'h0), 64'h0000_000F_0FFF_FFFF);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {63'h0, stallreq_o}, 64'h0);
        chk("reset_whilo", {63'h0, whilo_o}, 64'h0);
        chk("reset_hilo", {hi_o, lo_o}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op("madd", EXE_MADD_OP, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h10, 1, 32'h0, 32'h0000_000A);
        do_op("msubu", EXE_MSUBU_OP, 32'hFFFF_FFFF, 32'd2, 32'h2, 32'h0, 1, 32'h0, 32'h0000_0002);
        do_op("div_neg", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 33, 32'h0, 32'h8000_0000);
        do_op("divu", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'h0, 33, 32'h0000_000F, 32'h0FFF_FFFF);
        do_op("div_zero", EXE_DIV_OP, 32'h1234_5678, 32'h0, 32'hAAAA_AAAA, 32'h5555_5555, 1, 32'h0, 32'h0);

        // Annul in stall cycle 10, then a fresh divide.
        aluop_i = EXE_DIVU_OP; reg1_i = 32'd5000; reg2_i = 32'd3;
        repeat (9) @(posedge clk);
        #1 annul_i = 1'b1;
        @(negedge clk);
        chk("annul_stall", {63'h0, stallreq_o}, 64'h0);
        chk("annul_whilo", {63'h0, whilo_o}, 64'h0);
        @(posedge clk); #1;
        annul_i = 1'b0;
        do_op("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'h0, 32'h0, 33, 32'd2, 32'd14);

        // Reset in DIV_RUN cycle 5 abandons the divide.
        aluop_i = EXE_DIVU_OP; reg1_i = 32'd1000; reg2_i = 32'd3;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; aluop_i = 8'h00;
        @(negedge clk);
        chk("rstabort_stall", {63'h0, stallreq_o}, 64'h0);
        chk("rstabort_whilo", {63'h0, whilo_o}, 64'h0);
        chk("rstabort_hilo", {hi_o, lo_o}, 64'h0);
        nw = 0;
        repeat (40) begin
            @(negedge clk);
            if (whilo_o) nw++;
        end
        chk("rstabort_no_write", 64'(nw), 64'h0);

        // Randomized traffic; the every-cycle compare process does the checking.
        for (int i = 0; i < 5000; i++) begin
            int r;
            @(posedge clk); #1;
            annul_i = 1'b0;
            rst     = 1'b0;
            if (!m_active) begin
                aluop_i = pick_op($urandom_range(0, 8));
                reg1_i  = $urandom;
                reg2_i  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
                hi_i    = $urandom;
                lo_i    = $urandom;
                if ($urandom_range(0, 9) == 0) begin
                    reg1_i = 32'h8000_0000;
                    reg2_i = 32'hFFFF_FFFF;
                end
            end else if ($urandom_range(0, 59) == 0) begin
                aluop_i = 8'h00;
            end
            r = $urandom_range(0, 99);
            if (r == 0) begin
                rst     = 1'b1;
                aluop_i = 8'h00;
            end else if (r < 3) begin
                annul_i = 1'b1;
            end
        end
        @(posedge clk); #1;
        aluop_i = 8'h00; annul_i = 1'b0; rst = 1'b0;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_muldiv_seq
`default_nettype wire
